// File: rtl/count_uart_tx_if.sv
// Valid/ready byte handshake between the counter
// and the UART serialiser.
interface count_uart_tx_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/count_uart_tx.sv
// UART transmitter for counter samples:
// 8N1/8E1/8N2/8E2 framing, LSB first.
module count_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   count_uart_tx_if.slave    up,
   output logic              tx,
   output logic              busy,
   output logic [7:0]        frame_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
   localparam bit          HAS_PAR   = (PARITY_EN != 0);

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  sh_q, sh_d;
   logic        par_q, par_d;
   logic        tx_q, tx_d;
   logic        rdy_q, rdy_d;
   logic        busy_q, busy_d;
   logic [7:0]  fc_q, fc_d;
   logic        baud_end;

   assign baud_end      = (baud_q == BAUD_MAX);
   assign tx            = tx_q;
   assign busy          = busy_q;
   assign frame_count   = fc_q;
   assign up.data_ready = rdy_q;

   // State and output registers; reset abandons any frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         fc_q    <= fc_d;
      end
   end

   // Next state; tx_d is the level of the bit being entered.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      par_d   = par_q;
      tx_d    = tx_q;
      rdy_d   = rdy_q;
      busy_d  = busy_q;
      fc_d    = fc_q;
      unique case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (up.data_valid && rdy_q) begin
               sh_d    = up.data_in;
               par_d   = ^up.data_in;
               state_d = S_START;
               tx_d    = 1'b0;
               rdy_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_DATA;
               tx_d    = sh_q[0];
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d = '0;
                  if (HAS_PAR) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
                  sh_d  = sh_q >> 1;
                  tx_d  = sh_q[1];
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_PARITY: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_STOP;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
                  rdy_d   = 1'b1;
                  busy_d  = 1'b0;
                  fc_d    = fc_q + 8'd1;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: three framing variants
// checked against a bit-list frame model.
module tb_count_uart_tx;

   localparam int C = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  din [3];
   logic [2:0]  dv;
   logic [2:0]  tx_w;
   logic [2:0]  busy_w;
   logic [2:0]  rdy_w;
   logic [23:0] fc_w;
   logic [7:0]  fc_exp [3];
   int          vectors = 0;
   int          miscompares = 0;
   time         last_acc = 0;
   time         t1;

   always #5 clk = ~clk;

   count_uart_tx_if if0 ();
   count_uart_tx_if if1 ();
   count_uart_tx_if if2 ();

   assign if0.data_in    = din[0];
   assign if0.data_valid = dv[0];
   assign rdy_w[0]       = if0.data_ready;
   assign if1.data_in    = din[1];
   assign if1.data_valid = dv[1];
   assign rdy_w[1]       = if1.data_ready;
   assign if2.data_in    = din[2];
   assign if2.data_valid = dv[2];
   assign rdy_w[2]       = if2.data_ready;

   count_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(1)) u_8n1 (
      .clk         (clk),
      .rst         (rst),
      .up          (if0),
      .tx          (tx_w[0]),
      .busy        (busy_w[0]),
      .frame_count (fc_w[7:0])
   );

   count_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(1)) u_8e1 (
      .clk         (clk),
      .rst         (rst),
      .up          (if1),
      .tx          (tx_w[1]),
      .busy        (busy_w[1]),
      .frame_count (fc_w[15:8])
   );

   count_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(2)) u_8n2 (
      .clk         (clk),
      .rst         (rst),
      .up          (if2),
      .tx          (tx_w[2]),
      .busy        (busy_w[2]),
      .frame_count (fc_w[23:16])
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Frame as a list of bit slots: start, d0..d7, [even parity], stops.
   function automatic logic exp_bit(logic [7:0] d, int par, int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return d[j-1];
      if (par != 0 && j == 9) return ($countones(d) % 2) == 1;
      return 1'b1;
   endfunction

   task automatic send(int k, logic [7:0] d, logic [7:0] nxt,
                       bit keep, bit scramble);
      int par;
      int stops;
      int n;
      logic [7:0] dec;
      par   = (k == 1) ? 1 : 0;
      stops = (k == 2) ? 2 : 1;
      n     = 1 + 8 + par + stops;
      dec   = '0;
      chk("ready_before_accept", 32'(rdy_w[k]), 32'd1);
      din[k] = d;
      dv[k]  = 1'b1;
      cyc();
      last_acc = $time;
      din[k] = nxt;
      dv[k]  = keep;
      for (int c = 0; c < n * C; c++) begin
         int j;
         j = c / C;
         if (scramble) din[k] = 8'($urandom);
         chk("tx_busy_ready", {29'd0, tx_w[k], busy_w[k], rdy_w[k]},
             {29'd0, exp_bit(d, par, j), 2'b10});
         if (c % C == C / 2 && j >= 1 && j <= 8) dec[j-1] = tx_w[k];
         if (par != 0 && c % C == C / 2 && j == 9)
            chk("parity_bit", 32'(tx_w[k]), 32'($countones(d) % 2));
         cyc();
      end
      fc_exp[k] = fc_exp[k] + 8'd1;
      chk("decoded_byte", 32'(dec), 32'(d));
      chk("idle_after_frame", {29'd0, tx_w[k], busy_w[k], rdy_w[k]},
          32'b101);
      chk("frame_count", 32'(fc_w[k*8 +: 8]), 32'(fc_exp[k]));
   endtask

   initial begin
      din[0] = '0;
      din[1] = '0;
      din[2] = '0;
      dv     = '0;
      fc_exp[0] = '0;
      fc_exp[1] = '0;
      fc_exp[2] = '0;

      // Reset held, then quiet idle line for 100 cycles.
      repeat (3) cyc();
      chk("in_reset", {20'd0, tx_w[0], busy_w[0], rdy_w[0], fc_w[7:0]},
          {20'd0, 1'b1, 1'b0, 1'b1, 8'd0});
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         for (int k = 0; k < 3; k++)
            chk("idle_after_reset",
                {20'd0, tx_w[k], busy_w[k], rdy_w[k], fc_w[k*8 +: 8]},
                {20'd0, 1'b1, 1'b0, 1'b1, 8'd0});
      end

      // Reset in the middle of data bit 4 of 8'h3C.
      din[0] = 8'h3C;
      dv[0]  = 1'b1;
      cyc();
      dv[0]  = 1'b0;
      repeat (5 * C + C / 2) cyc();
      chk("mid_bit4_tx", 32'(tx_w[0]), 32'd1);
      chk("mid_bit4_busy", {30'd0, busy_w[0], rdy_w[0]}, 32'b10);
      rst = 1'b1;
      #1;
      chk("async_rst_state", {29'd0, tx_w[0], busy_w[0], rdy_w[0]},
          32'b101);
      chk("async_rst_fc", 32'(fc_w[7:0]), 32'd0);
      cyc();
      rst = 1'b0;
      cyc();
      send(0, 8'h3C, 8'h00, 1'b0, 1'b0);

      // 8N1 0xA5.
      cyc();
      send(0, 8'hA5, 8'h00, 1'b0, 1'b0);

      // 8E1: odd and even weight data.
      cyc();
      send(1, 8'h07, 8'h00, 1'b0, 1'b0);
      send(1, 8'h03, 8'h00, 1'b0, 1'b0);

      // 8N2 back-to-back with valid held high.
      cyc();
      send(2, 8'hFE, 8'hFF, 1'b1, 1'b0);
      t1 = last_acc;
      send(2, 8'hFF, 8'h00, 1'b1, 1'b0);
      chk("b2b_period", 32'((last_acc - t1) / 10), 32'd177);
      t1 = last_acc;
      send(2, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("b2b_period2", 32'((last_acc - t1) / 10), 32'd177);

      // Random frames on the parity and two-stop variants.
      for (int i = 0; i < 4; i++) begin
         send(1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
         send(2, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      end

      // 256 random frames with data_in churned while busy.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      fc_exp[0] = '0;
      fc_exp[1] = '0;
      fc_exp[2] = '0;
      cyc();
      for (int i = 0; i < 256; i++)
         send(0, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      chk("frame_count_wrap", 32'(fc_w[7:0]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
